// File: rtl/l2_evict_buffer.sv
// L2 eviction buffer: captures one dirty line and writes it to memory in beats.
// Define L2_EVICT_FWD_EN to enable forwarding of the held line to L2 misses.
module l2_evict_buffer #(
   parameter int s_offset = 5,
   parameter int s_burst  = 64,
   localparam int s_line  = 8 * (2 ** s_offset)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                evict_req,
   input  logic [31:0]         evict_addr,
   input  logic [s_line-1:0]   evict_line,
   output logic                evict_ack,
   output logic                busy,
   output logic                done,
   output logic                pmem_write,
   output logic [31:0]         pmem_address,
   output logic [s_burst-1:0]  pmem_wdata,
   input  logic                pmem_resp,
   input  logic [31:0]         chk_addr,
   output logic                fwd_hit,
   output logic [s_line-1:0]   fwd_line
);

   localparam int BEATS = s_line / s_burst;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      DONE
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [BW-1:0]       r_beat;
   logic [s_line-1:0]   r_line;
   logic [31:0]         r_addr;
   logic                w_cap;
   logic                w_adv;
   logic                w_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_cap  = 1'b0;
      w_adv  = 1'b0;
      w_last = (r_beat == LAST);
      unique case (r_state)
         IDLE: begin
            if (evict_req) begin
               w_cap  = 1'b1;
               w_next = SEND;
            end
         end
         SEND: begin
            if (pmem_resp) begin
               w_adv = 1'b1;
               if (w_last) w_next = DONE;
            end
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_beat <= '0;
         r_line <= '0;
         r_addr <= '0;
      end else if (w_cap) begin
         r_beat <= '0;
         r_line <= evict_line;
         r_addr <= {evict_addr[31:s_offset], {s_offset{1'b0}}};
      end else if (w_adv) begin
         r_beat <= w_last ? '0 : r_beat + 1'b1;
      end
   end

   // rst gates the ack so it reads 0 while reset is held
   assign evict_ack    = (r_state == IDLE) && evict_req && !rst;
   assign busy         = (r_state != IDLE);
   assign done         = (r_state == DONE);
   assign pmem_write   = (r_state == SEND);
   assign pmem_address = pmem_write ? r_addr : '0;
   assign pmem_wdata   = pmem_write ? r_line[s_burst*r_beat +: s_burst]
                                    : '0;

`ifdef L2_EVICT_FWD_EN
   logic w_match;
   logic w_unused;
   assign w_match  = (chk_addr[31:s_offset] == r_addr[31:s_offset]);
   assign fwd_hit  = busy && w_match;
   assign fwd_line = r_line;
   assign w_unused = ^{chk_addr[s_offset-1:0], r_addr[s_offset-1:0],
                       evict_addr[s_offset-1:0]};
`else
   logic w_unused;
   assign fwd_hit  = 1'b0;
   assign fwd_line = '0;
   assign w_unused = ^{chk_addr, r_addr[s_offset-1:0],
                       evict_addr[s_offset-1:0]};
`endif

endmodule

// File: tb/tb_l2_evict_buffer.sv
// Randomized bench for l2_evict_buffer against a queue-based line/beat model.
// Honours L2_EVICT_FWD_EN the same way as the design.
module tb_l2_evict_buffer;

   localparam int OFS   = 5;
   localparam int BURST = 64;
   localparam int LINE  = 256;
   localparam int BEATS = LINE / BURST;

   logic              clk;
   logic              rst;
   logic              evict_req;
   logic [31:0]       evict_addr;
   logic [LINE-1:0]   evict_line;
   logic              evict_ack;
   logic              busy;
   logic              done;
   logic              pmem_write;
   logic [31:0]       pmem_address;
   logic [BURST-1:0]  pmem_wdata;
   logic              pmem_resp;
   logic [31:0]       chk_addr;
   logic              fwd_hit;
   logic [LINE-1:0]   fwd_line;

   l2_evict_buffer #(.s_offset(OFS), .s_burst(BURST)) dut (
      .clk          (clk),
      .rst          (rst),
      .evict_req    (evict_req),
      .evict_addr   (evict_addr),
      .evict_line   (evict_line),
      .evict_ack    (evict_ack),
      .busy         (busy),
      .done         (done),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_resp    (pmem_resp),
      .chk_addr     (chk_addr),
      .fwd_hit      (fwd_hit),
      .fwd_line     (fwd_line)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int n_acks   = 0;
   int n_dones  = 0;

   // reference model: held line, pending beats, one-cycle done flag
   logic [BURST-1:0] m_q[$];
   logic             m_done;
   logic [31:0]      m_addr;
   logic [LINE-1:0]  m_line;

   task automatic check(input string tag, input logic [LINE-1:0] got,
                        input logic [LINE-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [LINE-1:0] rand_line();
      logic [LINE-1:0] l;
      for (int i = 0; i < LINE / 32; i++) l[32*i +: 32] = $urandom;
      return l;
   endfunction

   task automatic step(input logic r, input logic req,
                       input logic [31:0] a, input logic [LINE-1:0] l,
                       input logic resp, input logic [31:0] chk);
      logic e_idle, e_send, e_busy, e_ack, e_hit;
      logic [LINE-1:0] e_fline;
      rst        = r;
      evict_req  = req;
      evict_addr = a;
      evict_line = l;
      pmem_resp  = resp;
      chk_addr   = chk;
      #2;
      if (r) begin
         m_q.delete();
         m_done = 1'b0;
         m_addr = '0;
         m_line = '0;
      end
      e_send = (m_q.size() > 0);
      e_idle = !e_send && !m_done;
      e_busy = !e_idle;
      e_ack  = e_idle && req && !r;
`ifdef L2_EVICT_FWD_EN
      e_hit   = e_busy && (chk[31:OFS] == m_addr[31:OFS]);
      e_fline = m_line;
`else
      e_hit   = 1'b0;
      e_fline = '0;
`endif
      check("ack",   LINE'(evict_ack),  LINE'(e_ack));
      check("busy",  LINE'(busy),       LINE'(e_busy));
      check("done",  LINE'(done),       LINE'(m_done));
      check("write", LINE'(pmem_write), LINE'(e_send));
      check("addr",  LINE'(pmem_address), LINE'(e_send ? m_addr : 32'h0));
      check("wdata", LINE'(pmem_wdata),
            LINE'(e_send ? m_q[0] : {BURST{1'b0}}));
      check("fhit",  LINE'(fwd_hit),    LINE'(e_hit));
      check("fline", fwd_line,          e_fline);
      if (evict_ack) n_acks++;
      if (done) n_dones++;
      if (!r) begin
         if (m_done) m_done = 1'b0;
         else if (e_send) begin
            if (resp) begin
               void'(m_q.pop_front());
               if (m_q.size() == 0) m_done = 1'b1;
            end
         end else if (req) begin
            m_addr = {a[31:OFS], {OFS{1'b0}}};
            m_line = l;
            for (int b = 0; b < BEATS; b++) m_q.push_back(l[BURST*b +: BURST]);
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   logic [LINE-1:0] seq_line;
   logic [31:0]     ra;
   logic [LINE-1:0] rl;
   int              n_before;

   initial begin
      m_done = 1'b0;
      m_addr = '0;
      m_line = '0;
      for (int i = 0; i < LINE / 8; i++) seq_line[8*i +: 8] = 8'(i);
      rst = 1'b1;
      evict_req = 1'b0; evict_addr = '0; evict_line = '0;
      pmem_resp = 1'b0; chk_addr = '0;
      @(posedge clk);
      #1;
      step(1, 1, 32'h1234, seq_line, 1, 32'h1234);
      step(1, 0, 0, 0, 0, 0);

      // basic burst, memory always ready
      step(0, 1, 32'h1234, seq_line, 1, 32'h123C);
      check("beat0_const", LINE'(pmem_wdata), LINE'(64'h0706050403020100));
      check("addr_const", LINE'(pmem_address), LINE'(32'h1220));
      for (int i = 0; i < BEATS; i++) step(0, 0, 0, 0, 1, 32'h123C);
      check("done_c5", LINE'(done), LINE'(1'b1));
      step(0, 0, 0, 0, 1, 32'h1240);
      step(0, 0, 0, 0, 1, 32'h123C);

      // memory stalls 3 cycles before every beat
      step(0, 1, 32'h1234, seq_line, 0, 32'h1240);
      for (int i = 0; i < 4 * BEATS; i++)
         step(0, 0, 0, 0, (i % 4) == 3, 32'h123C);
      check("done_c17", LINE'(done), LINE'(1'b1));
      step(0, 0, 0, 0, 0, 0);

      // request held high: re-acked only in IDLE after DONE
      n_before = n_acks;
      for (int i = 0; i < 3 * (BEATS + 2); i++)
         step(0, 1, 32'h8000_0040, ~seq_line, 1, 32'h8000_0050);
      check("held_acks", LINE'(n_acks - n_before), LINE'(3));
      step(0, 0, 0, 0, 1, 0);
      for (int i = 0; i < BEATS + 1; i++) step(0, 0, 0, 0, 1, 0);

      // reset during beat 2, then a fresh request
      step(0, 1, 32'h1234, seq_line, 1, 32'h1234);
      step(0, 0, 0, 0, 1, 32'h1234);
      step(0, 0, 0, 0, 1, 32'h1234);
      n_before = n_dones;
      step(1, 0, 0, 0, 1, 32'h1234);
      step(0, 0, 0, 0, 1, 32'h1234);
      check("no_done_rst", LINE'(n_dones - n_before), LINE'(0));
      step(0, 1, 32'h1234, seq_line, 1, 32'h1234);
      check("restart_b0", LINE'(pmem_wdata), LINE'(64'h0706050403020100));
      for (int i = 0; i < BEATS + 1; i++) step(0, 0, 0, 0, 1, 32'h1234);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         ra = $urandom;
         if ($urandom_range(0, 3) == 0) ra = {m_addr[31:OFS], 5'(ra)};
         rl = rand_line();
         step($urandom_range(0, 99) < 2, $urandom_range(0, 2) == 0,
              $urandom, rl, $urandom_range(0, 1) == 1,
              ($urandom_range(0, 1) == 1) ? ra : {m_addr[31:OFS], 5'(ra)});
      end
      step(0, 0, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
